// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter
//   Request/grant arbiter in front of the shared data memory. Three requesters
//   share one memory port with fixed priority host > CPU > accelerator. The
//   accelerator path is buffered in a small FIFO so it can issue back-to-back
//   without holding its request. Read data returns one cycle after grant and
//   is steered to the requester that owned the read.
//
//   Optional feature macro: ARB_STARVE_EN
//     When defined, a starvation counter lets a non-empty accel FIFO win over
//     the CPU for one grant after STARVE_LIMIT consecutive blocked cycles.
//
//   Ports
//     clk, rst_n                        clock, async active-low reset
//     ex_wrt_en/ex_addr/ex_wrt_data     host write port (always serviced)
//     cpu_req/cpu_we/cpu_addr/...       CPU load/store request
//     cpu_stall                         CPU request not granted this cycle
//     cpu_rd_valid/cpu_rd_data          CPU read return (32 bits)
//     accel_req_valid/accel_req_ready   accelerator FIFO push handshake
//     accel_we/accel_addr/...           accelerator request payload
//     accel_rd_valid/accel_rd_data      accelerator read return (512 bits)
//     mem_addr/mem_wrt_data/mem_wrt_en  memory request
//     mem_rd_data                       memory read data, one cycle after address

module cpu_mem_arbiter #(
  parameter int unsigned ACCEL_FIFO_DEPTH = 4,
  parameter int unsigned STARVE_LIMIT     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ex_wrt_en,
  input  logic [15:0]  ex_addr,
  input  logic [31:0]  ex_wrt_data,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [15:0]  cpu_addr,
  input  logic [31:0]  cpu_wrt_data,
  output logic         cpu_stall,
  output logic         cpu_rd_valid,
  output logic [31:0]  cpu_rd_data,
  input  logic         accel_req_valid,
  output logic         accel_req_ready,
  input  logic         accel_we,
  input  logic [15:0]  accel_addr,
  input  logic [31:0]  accel_wrt_data,
  output logic         accel_rd_valid,
  output logic [511:0] accel_rd_data,
  output logic [15:0]  mem_addr,
  output logic [31:0]  mem_wrt_data,
  output logic         mem_wrt_en,
  input  logic [511:0] mem_rd_data
);

  localparam int unsigned PtrW = (ACCEL_FIFO_DEPTH > 1) ? $clog2(ACCEL_FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(ACCEL_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    OwnNone,
    OwnCpu,
    OwnAccel
  } owner_e;

  // FIFO storage, split by field
  logic            r_fifo_we   [ACCEL_FIFO_DEPTH];
  logic [15:0]     r_fifo_addr [ACCEL_FIFO_DEPTH];
  logic [31:0]     r_fifo_data [ACCEL_FIFO_DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  owner_e          r_rd_owner;

  logic w_fifo_empty;
  logic w_fifo_full;
  logic w_push;
  logic w_pop;
  logic w_host_gnt;
  logic w_cpu_gnt;
  logic w_accel_gnt;
  logic w_force_accel;

  logic        w_head_we;
  logic [15:0] w_head_addr;
  logic [31:0] w_head_data;

  assign w_fifo_empty    = (r_count == '0);
  assign w_fifo_full     = (r_count == CntW'(ACCEL_FIFO_DEPTH));
  assign accel_req_ready = !w_fifo_full;
  assign w_push          = accel_req_valid && !w_fifo_full;
  assign w_pop           = w_accel_gnt;

  assign w_head_we   = r_fifo_we[r_rd_ptr];
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

`ifdef ARB_STARVE_EN
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  logic [StarveW-1:0] r_starve_cnt;

  assign w_force_accel = !w_fifo_empty && (r_starve_cnt >= StarveW'(STARVE_LIMIT));

  // Counts cycles the CPU wins over a waiting accel head; any accel grant or
  // an empty FIFO restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_fifo_empty || w_accel_gnt) begin
      r_starve_cnt <= '0;
    end else if (w_cpu_gnt) begin
      r_starve_cnt <= r_starve_cnt + StarveW'(1);
    end
  end
`else
  logic w_unused_starve;
  assign w_unused_starve = ^STARVE_LIMIT;
  assign w_force_accel   = 1'b0;
`endif

  // Host always wins; the starvation guard only reorders CPU vs accel.
  assign w_host_gnt  = ex_wrt_en;
  assign w_cpu_gnt   = !ex_wrt_en && cpu_req && !w_force_accel;
  assign w_accel_gnt = !ex_wrt_en && !w_fifo_empty && (!cpu_req || w_force_accel);
  assign cpu_stall   = cpu_req && !w_cpu_gnt;

  always_comb begin
    mem_addr     = '0;
    mem_wrt_data = '0;
    mem_wrt_en   = 1'b0;
    if (w_host_gnt) begin
      mem_addr     = ex_addr;
      mem_wrt_data = ex_wrt_data;
      mem_wrt_en   = 1'b1;
    end else if (w_cpu_gnt) begin
      mem_addr     = cpu_addr;
      mem_wrt_data = cpu_wrt_data;
      mem_wrt_en   = cpu_we;
    end else if (w_accel_gnt) begin
      mem_addr     = w_head_addr;
      mem_wrt_data = w_head_data;
      mem_wrt_en   = w_head_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  // Payload storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_we[r_wr_ptr]   <= accel_we;
      r_fifo_addr[r_wr_ptr] <= accel_addr;
      r_fifo_data[r_wr_ptr] <= accel_wrt_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_owner <= OwnNone;
    end else if (w_cpu_gnt && !cpu_we) begin
      r_rd_owner <= OwnCpu;
    end else if (w_accel_gnt && !w_head_we) begin
      r_rd_owner <= OwnAccel;
    end else begin
      r_rd_owner <= OwnNone;
    end
  end

  assign cpu_rd_valid   = (r_rd_owner == OwnCpu);
  assign cpu_rd_data    = mem_rd_data[31:0];
  assign accel_rd_valid = (r_rd_owner == OwnAccel);
  assign accel_rd_data  = mem_rd_data;

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Request/grant arbiter placed in front of the shared data memory (cpu_datamem_mem). It is instantiated before the CPU pipeline register.
- Shares the single memory port between three requesters:
  - host write port (ex)
  - CPU load/store port
  - accelerator port
- Accelerator requests are buffered in a small FIFO, so the accelerator can issue back-to-back without holding its request.
- Read data returns one cycle after grant and is steered to the requester that owned the read.

Parameters:
- ACCEL_FIFO_DEPTH, 4, accelerator request FIFO entries (power of two, >=2)
- STARVE_LIMIT, 8, consecutive cycles a non-empty accel FIFO may be blocked by the CPU before it is forced through (starvation guard only)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ex_wrt_en  in  1  host write request (write-only, always serviced)
- ex_addr  in  16  host address
- ex_wrt_data  in  32  host write data
- cpu_req  in  1  CPU access request (held until not stalled)
- cpu_we  in  1  CPU access is a write
- cpu_addr  in  16  CPU address
- cpu_wrt_data  in  32  CPU write data
- cpu_stall  out  1  CPU request not granted this cycle
- cpu_rd_valid  out  1  CPU read data valid
- cpu_rd_data  out  32  CPU read data
- accel_req_valid  in  1  accelerator request valid
- accel_req_ready  out  1  FIFO can accept a request
- accel_we  in  1  accelerator access is a write
- accel_addr  in  16  accelerator address
- accel_wrt_data  in  32  accelerator write data
- accel_rd_valid  out  1  accelerator read data valid
- accel_rd_data  out  512  accelerator read line
- mem_addr  out  16  memory address
- mem_wrt_data  out  32  memory write data
- mem_wrt_en  out  1  memory write enable
- mem_rd_data  in  512  memory read data, registered, valid the cycle after address presented

Behaviour:
- Reset:
  - Clears the FIFO (empty) and the starve counter.
  - Sets rd_owner to NONE.
  - cpu_rd_valid=0, accel_rd_valid=0, accel_req_ready=1.
  - mem_* outputs are 0 because nothing is granted.
- FIFO:
  - Entry = {we, addr, wrt_data}.
  - accel_req_ready = !full. It is registered-free, derived from the count.
  - Push when accel_req_valid && accel_req_ready.
  - Pop when the head is granted.
  - Push and pop in the same cycle leave the count unchanged.
  - There is no pass-through: when the FIFO is empty, a request is granted at the earliest the cycle after the push.
  - Pointers wrap modulo ACCEL_FIFO_DEPTH.
- Grant is combinational each cycle. Priority order:
  1. host when ex_wrt_en;
  2. else CPU when cpu_req;
  3. else FIFO head when non-empty.
- Exactly one grant drives mem_addr/mem_wrt_data/mem_wrt_en.
- With no grant: mem_wrt_en=0, and mem_addr/mem_wrt_data=0.
- cpu_stall = cpu_req && !cpu_grant.
  - The CPU holds cpu_addr/cpu_we/cpu_wrt_data stable while stalled.
- Read return:
  - rd_owner register is set to CPU or ACCEL when a read is granted, else NONE.
  - Next cycle:
    - cpu_rd_valid = (rd_owner==CPU), cpu_rd_data = mem_rd_data[31:0];
    - accel_rd_valid = (rd_owner==ACCEL), accel_rd_data = mem_rd_data.
  - Both valids are 0 otherwise.
  - Read latency from grant is 1 cycle. Writes produce no response.
- Ordering:
  - Accel requests are serviced strictly in FIFO order.
  - The CPU sees at most one outstanding read.
- Host and CPU in the same cycle: the CPU stalls one cycle per host write. A host write every cycle stalls the CPU indefinitely; this is accepted behaviour.
- Reset asserted mid-operation: FIFO contents are discarded and any pending read-return valid is dropped.

Optional Feature:
- ARB_STARVE_EN: starvation guard.
- When defined:
  - A counter increments each cycle the FIFO is non-empty and the CPU is granted over it.
  - The counter clears when the FIFO head is granted or the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, the FIFO head takes priority over the CPU for one grant. The host still wins.
  - The counter then clears.
- When undefined: strict host > CPU > accel priority, and no counter logic is present.

Test Plan:
- Reset, then idle:
  - accel_req_ready=1, cpu_stall=0, both rd_valids=0, mem_wrt_en=0.
- Host write vs CPU read:
  - Cycle 0: ex_wrt_en=1 to 0x0010 with data 0xDEADBEEF, and cpu_req read of 0x0010.
  - Required: cycle 0 mem_addr=0x0010, mem_wrt_en=1, cpu_stall=1.
  - Cycle 1: CPU granted, cpu_stall=0.
  - Cycle 2: cpu_rd_valid=1, cpu_rd_data=0xDEADBEEF.
- Accel burst:
  - Push 5 writes with the CPU idle and DEPTH=4.
  - Required: accel_req_ready stays 1 because the drain rate matches the push rate.
  - Addresses reach the memory in order, 1 cycle after each push.
- FIFO full:
  - Hold cpu_req=1 continuously with the guard off, and push accel requests.
  - Required: after 4 pushes accel_req_ready=0, and no accel grant while cpu_req=1.
  - Drop cpu_req: the head drains on the next cycle and ready returns the cycle after the pop.
- Accel read:
  - Write 0x1 to 0x0040 via the host, then accel read 0x0040.
  - Required: accel_rd_valid=1 two cycles after the push, accel_rd_data[31:0]=0x1, cpu_rd_valid=0.
- Starvation (ARB_STARVE_EN, STARVE_LIMIT=8):
  - Hold cpu_req=1 and push one accel read.
  - Required: cpu_stall=1 exactly once, on the 9th cycle after the push; the accel head is granted that cycle.
  - Without the macro: cpu_stall is never asserted.
